// File: rtl/freq_sweep_pkg.sv
// Shared types and constants for the frequency sweep block.
// Holds the FSM encoding, widths and parameter sanitising helpers.
package freq_sweep_pkg;

  localparam int PHASE_W = 32;
  localparam int DWELL_W = 24;

  localparam logic [PHASE_W-1:0] RST_PHASE_INC = 32'd100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FINAL = 2'd2
  } state_e;

  // Dwell of 0 behaves like 1, so both reload the counter with 0.
  function automatic logic [DWELL_W-1:0] dwell_m1(
    input logic [DWELL_W-1:0] d
  );
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  function automatic logic [PHASE_W-1:0] step_eff(
    input logic [PHASE_W-1:0] s
  );
    return (s == '0) ? PHASE_W'(1) : s;
  endfunction

endpackage

// File: rtl/freq_sweep_if.sv
// Control and status bundle between a sweep controller and freq_sweep.
// The master drives sweep parameters; the slave returns phase and status.
interface freq_sweep_if;
  import freq_sweep_pkg::*;

  logic               start;
  logic               abort;
  logic               mode;
  logic [PHASE_W-1:0] f_start;
  logic [PHASE_W-1:0] f_stop;
  logic [PHASE_W-1:0] f_step;
  logic [DWELL_W-1:0] dwell;
  logic [PHASE_W-1:0] f_idle;
  logic [PHASE_W-1:0] phase_inc;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, mode,
    output f_start, f_stop, f_step,
    output dwell, f_idle,
    input  phase_inc, busy, done
  );

  modport slave (
    input  start, abort, mode,
    input  f_start, f_stop, f_step,
    input  dwell, f_idle,
    output phase_inc, busy, done
  );

endinterface

// File: rtl/freq_sweep_timer.sv
// Dwell down-counter: loads on request, otherwise counts to zero and holds.
// zero is high whenever the current step's dwell has run out.
module sweep_timer
  import freq_sweep_pkg::*;
(
  input  logic               clk60,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk60) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/freq_sweep.sv
// Phase-increment sweep generator feeding a DDS phaseInc port.
// Steps from f_start to f_stop, clamping at f_stop, single or continuous.
module freq_sweep
  import freq_sweep_pkg::*;
(
  input  logic        clk60,
  input  logic        rst,
  freq_sweep_if.slave bus
);

  state_e             state_q;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] start_q;
  logic [PHASE_W-1:0] stop_q;
  logic [PHASE_W-1:0] step_q;
  logic [DWELL_W-1:0] dm1_q;
  logic               mode_q;
  logic               busy_q;
  logic               done_q;

  logic               go;
  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_zero;
  logic [PHASE_W:0]   next;

  assign go   = bus.start & ~bus.abort;
  // Extra bit keeps carry-out so the clamp catches overflow.
  assign next = {1'b0, phase_q} + {1'b0, step_eff(step_q)};

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          tmr_load = 1'b1;
          tmr_val  = dwell_m1(bus.dwell);
        end
      end
      SWEEP, FINAL: begin
        if (bus.abort) begin
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          if (state_q == SWEEP || mode_q) begin
            tmr_val = dm1_q;
          end
        end
      end
      default: begin
        tmr_load = 1'b1;
      end
    endcase
  end

  sweep_timer u_timer (
    .clk60    (clk60),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk60) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= RST_PHASE_INC;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dm1_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          phase_q <= bus.f_idle;
          if (go) begin
            start_q <= bus.f_start;
            stop_q  <= bus.f_stop;
            step_q  <= bus.f_step;
            dm1_q   <= dwell_m1(bus.dwell);
            mode_q  <= bus.mode;
            phase_q <= bus.f_start;
            busy_q  <= 1'b1;
            state_q <= (bus.f_start < bus.f_stop) ? SWEEP : FINAL;
          end
        end
        SWEEP: begin
          if (bus.abort) begin
            state_q <= IDLE;
            phase_q <= bus.f_idle;
            busy_q  <= 1'b0;
          end else if (tmr_zero) begin
            if (next >= {1'b0, stop_q}) begin
              phase_q <= stop_q;
              state_q <= FINAL;
            end else begin
              phase_q <= next[PHASE_W-1:0];
            end
          end
        end
        FINAL: begin
          if (bus.abort) begin
            state_q <= IDLE;
            phase_q <= bus.f_idle;
            busy_q  <= 1'b0;
          end else if (tmr_zero) begin
            if (mode_q) begin
              phase_q <= start_q;
              state_q <= (start_q < stop_q) ? SWEEP : FINAL;
            end else begin
              state_q <= IDLE;
              phase_q <= bus.f_idle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= bus.f_idle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase_inc = phase_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_freq_sweep.sv
// Directed bench for freq_sweep: expected phase/busy/done per cycle
// are queued when a sweep is launched and popped as the DUT runs.
module tb_freq_sweep;
  import freq_sweep_pkg::*;

  logic clk60 = 1'b0;
  logic rst   = 1'b1;

  freq_sweep_if bus ();

  freq_sweep dut (
    .clk60 (clk60),
    .rst   (rst),
    .bus   (bus)
  );

  always #8 clk60 = ~clk60;

  typedef struct packed {
    logic [31:0] ph;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] IDLE_A = 32'd777;
  localparam logic [31:0] IDLE_B = 32'd888;

  task automatic tick();
    @(posedge clk60);
    #1;
  endtask

  task automatic check(input string tag, input exp_t e);
    exp_t got;
    got.ph   = bus.phase_inc;
    got.busy = bus.busy;
    got.done = bus.done;
    n_tests++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: phase_inc=%h busy=%b done=%b, expected phase_inc=%h busy=%b done=%b",
             tag, got.ph, got.busy, got.done, e.ph, e.busy, e.done);
    end
  endtask

  task automatic check_v(input string tag, input logic [31:0] ph,
                         input logic b, input logic d);
    exp_t e;
    e.ph   = ph;
    e.busy = b;
    e.done = d;
    check(tag, e);
  endtask

  task automatic push_seg(input logic [31:0] v, input int n);
    exp_t e;
    e.ph   = v;
    e.busy = 1'b1;
    e.done = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [31:0] idle);
    exp_t e;
    e.ph   = idle;
    e.busy = 1'b0;
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, e);
      tick();
    end
  endtask

  task automatic set_params(input logic [31:0] fs, input logic [31:0] fe,
                            input logic [31:0] st, input logic [23:0] dw,
                            input logic md);
    bus.f_start = fs;
    bus.f_stop  = fe;
    bus.f_step  = st;
    bus.dwell   = dw;
    bus.mode    = md;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.f_idle = IDLE_A;
    set_params(32'd0, 32'd0, 32'd0, 24'd0, 1'b0);

    // Reset holds the default increment even with start asserted.
    tick();
    bus.start = 1'b1;
    tick();
    tick();
    check_v("rst_hold", 32'd100000, 1'b0, 1'b0);
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    check_v("post_rst", IDLE_A, 1'b0, 1'b0);

    bus.f_idle = IDLE_B;
    check_v("idle_lat0", IDLE_A, 1'b0, 1'b0);
    tick();
    check_v("idle_lat1", IDLE_B, 1'b0, 1'b0);

    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_v("abort_idle", IDLE_B, 1'b0, 1'b0);

    // Basic sweep; inputs are scrambled after start.
    set_params(32'd100, 32'd130, 32'd10, 24'd4, 1'b0);
    pulse_start();
    set_params(32'd1, 32'd2, 32'd3, 24'd0, 1'b1);
    push_seg(32'd100, 4);
    push_seg(32'd110, 4);
    push_seg(32'd120, 4);
    push_seg(32'd130, 4);
    push_done(IDLE_B);
    drain("basic");
    check_v("basic_after", IDLE_B, 1'b0, 1'b0);

    // Overshoot clamp, with a start while busy.
    set_params(32'd100, 32'd130, 32'd25, 24'd4, 1'b0);
    pulse_start();
    set_params(32'd5, 32'd6, 32'd1, 24'd1, 1'b0);
    push_seg(32'd100, 4);
    push_seg(32'd125, 4);
    push_seg(32'd130, 4);
    push_done(IDLE_B);
    e = exp_q.pop_front();
    check("overshoot", e);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drain("overshoot");
    check_v("overshoot_after", IDLE_B, 1'b0, 1'b0);

    // Carry-out must clamp, not wrap.
    set_params(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd1, 1'b0);
    pulse_start();
    push_seg(32'hFFFF_FFF0, 1);
    push_seg(32'hFFFF_FFFF, 1);
    push_done(IDLE_B);
    drain("carry");
    check_v("carry_after", IDLE_B, 1'b0, 1'b0);

    // Continuous repeat, then abort mid-sweep.
    set_params(32'd100, 32'd130, 32'd10, 24'd4, 1'b1);
    pulse_start();
    push_seg(32'd100, 4);
    push_seg(32'd110, 4);
    push_seg(32'd120, 4);
    push_seg(32'd130, 4);
    push_seg(32'd100, 4);
    push_seg(32'd110, 4);
    drain("cont");
    check_v("cont_120", 32'd120, 1'b1, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_v("abort_sweep", IDLE_B, 1'b0, 1'b0);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_v("start_abort0", IDLE_B, 1'b0, 1'b0);
    tick();
    check_v("start_abort1", IDLE_B, 1'b0, 1'b0);

    // Zero dwell and zero step act as one.
    set_params(32'd5, 32'd7, 32'd0, 24'd0, 1'b0);
    pulse_start();
    push_seg(32'd5, 1);
    push_seg(32'd6, 1);
    push_seg(32'd7, 1);
    push_done(IDLE_B);
    drain("degen");
    check_v("degen_after", IDLE_B, 1'b0, 1'b0);

    // Start above stop goes straight to the final hold.
    set_params(32'd200, 32'd150, 32'd10, 24'd3, 1'b0);
    pulse_start();
    push_seg(32'd200, 3);
    push_done(IDLE_B);
    drain("rev");
    check_v("rev_after", IDLE_B, 1'b0, 1'b0);

    // Continuous with start above stop repeats the final hold.
    set_params(32'd200, 32'd150, 32'd10, 24'd5, 1'b1);
    pulse_start();
    push_seg(32'd200, 5);
    push_seg(32'd200, 5);
    drain("rev_cont");
    check_v("rev_cont_hold", 32'd200, 1'b1, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_v("abort_final", IDLE_B, 1'b0, 1'b0);

    // Reset mid-sweep overrides start and abort.
    set_params(32'd100, 32'd130, 32'd10, 24'd4, 1'b0);
    pulse_start();
    push_seg(32'd100, 4);
    push_seg(32'd110, 2);
    drain("pre_rst");
    rst = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    check_v("rst_mid0", 32'd100000, 1'b0, 1'b0);
    tick();
    check_v("rst_mid1", 32'd100000, 1'b0, 1'b0);
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    check_v("rst_exit", IDLE_B, 1'b0, 1'b0);

    set_params(32'd5, 32'd7, 32'd1, 24'd2, 1'b0);
    pulse_start();
    push_seg(32'd5, 2);
    push_seg(32'd6, 2);
    push_seg(32'd7, 2);
    push_done(IDLE_B);
    drain("post_rst_sweep");
    check_v("final_idle", IDLE_B, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
